// File: rtl/shifter_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
// The control struct is what travels down the pipe beside the data.
package shifter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_ROL = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            err;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One power-of-two level of the shifter: shifts or rotates by DIST when en_i is set.
// Purely combinational; the enclosing pipeline owns the registers.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                OP_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
                // MSB never changes under SRA, so replicating it here keeps the original sign.
                OP_SRA:  data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
                OP_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined shifter/rotator: one register per power-of-two level, one op per cycle.
// A single global advance enable stalls every stage together under output backpressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    logic                         adv;
    logic                         in_legal;
    logic [LOG2W-1:0]             vld_pipe_q, vld_pipe_d;
    logic [LOG2W-1:0][WIDTH-1:0]  data_q, data_d;
    logic [LOG2W-1:0][LOG2W-1:0]  amt_q, amt_d;
    ctrl_t [LOG2W-1:0]            ctrl_q, ctrl_d;

    logic [LOG2W-1:0][WIDTH-1:0]  lvl_in, lvl_out;
    logic [LOG2W-1:0][LOG2W-1:0]  lvl_amt;
    ctrl_t [LOG2W-1:0]            lvl_ctrl;

    assign adv      = !vld_pipe_q[LOG2W-1] || out_ready;
    assign in_ready = adv;
    assign in_legal = is_legal_op(in_op);

    genvar k;
    generate
        for (k = 0; k < LOG2W; k++) begin : g_lvl
            if (k == 0) begin : g_head
                // Illegal ops are zeroed on entry so every later level just passes them through.
                assign lvl_in[k]       = in_legal ? in_data : '0;
                assign lvl_amt[k]      = in_amt;
                assign lvl_ctrl[k].op  = in_op;
                assign lvl_ctrl[k].err = !in_legal;
            end else begin : g_body
                assign lvl_in[k]   = data_q[k-1];
                assign lvl_amt[k]  = amt_q[k-1];
                assign lvl_ctrl[k] = ctrl_q[k-1];
            end

            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_lvl (
                .data_i (lvl_in[k]),
                .op_i   (lvl_ctrl[k].op),
                .en_i   (lvl_amt[k][k]),
                .data_o (lvl_out[k])
            );
        end
    endgenerate

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        data_d     = data_q;
        amt_d      = amt_q;
        ctrl_d     = ctrl_q;
        if (adv) begin
            vld_pipe_d[0] = in_valid;
            for (int i = 1; i < LOG2W; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
            data_d = lvl_out;
            amt_d  = lvl_amt;
            ctrl_d = lvl_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            data_q     <= '0;
            amt_q      <= '0;
            ctrl_q     <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            data_q     <= data_d;
            amt_q      <= amt_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign out_valid = vld_pipe_q[LOG2W-1];
    assign out_data  = data_q[LOG2W-1];
    assign out_err   = ctrl_q[LOG2W-1].err;

    // Consumed amt bits and the last stage's op are dead past their level; fold them into a sink.
    logic unused_ctrl;
    assign unused_ctrl = ^{amt_q, ctrl_q[LOG2W-1].op};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed-vector and scoreboard bench for pipelined_barrel_shifter (WIDTH = 32).
module tb_pipelined_barrel_shifter;

    localparam int W  = 32;
    localparam int LW = 5;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [W-1:0]  in_data, out_data;
    logic [LW-1:0] in_amt;
    logic [2:0]    in_op;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string         name;
        logic [W-1:0]  data;
        logic [LW-1:0] amt;
        logic [2:0]    op;
        logic [W-1:0]  exp;
        logic          exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [LW-1:0] a,
                                         input logic [2:0] op);
        logic [W-1:0] r;
        int           s;
        s = int'(a);
        case (op)
            3'd0: r = d << s;
            3'd1: r = d >> s;
            3'd2: r = W'($signed(d) >>> s);
            3'd3: r = (s == 0) ? d : ((d << s) | (d >> (W - s)));
            3'd4: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
            default: return {1'b1, {W{1'b0}}};
        endcase
        return {1'b0, r};
    endfunction

    // Issue one op with out_ready high and check result and 5-cycle latency.
    task automatic run_vec(input vec_t v);
        int t;
        bit seen;
        @(negedge clk);
        in_data = v.data; in_amt = v.amt; in_op = v.op; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({v.name, " in_ready"}, in_ready, 1);
        t = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) fail_now({v.name, " out_valid"});
        else begin
            check({v.name, " data"}, out_data, v.exp);
            check({v.name, " err"}, out_err, v.exp_err);
            check({v.name, " latency"}, cyc - t, 5);
        end
    endtask

    task automatic wait_out(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) fail_now(name);
    endtask

    initial begin
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        logic [W-1:0] hold_data;
        logic         hold_err, stalled, acc_prev;
        int           sent, got, budget, ghosts, t;
        bit           seen;

        vecs[0]  = '{"sll4",      32'h000000F0, 5'd4,  3'b000, 32'h00000F00, 1'b0};
        vecs[1]  = '{"srl4",      32'h000000F0, 5'd4,  3'b001, 32'h0000000F, 1'b0};
        vecs[2]  = '{"sra4_neg",  32'h80000000, 5'd4,  3'b010, 32'hF8000000, 1'b0};
        vecs[3]  = '{"sra4_pos",  32'h40000000, 5'd4,  3'b010, 32'h04000000, 1'b0};
        vecs[4]  = '{"rol1",      32'h80000001, 5'd1,  3'b011, 32'h00000003, 1'b0};
        vecs[5]  = '{"ror1",      32'h00000001, 5'd1,  3'b100, 32'h80000000, 1'b0};
        vecs[6]  = '{"sll31",     32'hFFFFFFFF, 5'd31, 3'b000, 32'h80000000, 1'b0};
        vecs[7]  = '{"sra31",     32'hFFFFFFFF, 5'd31, 3'b010, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{"sll0",      32'hDEADBEEF, 5'd0,  3'b000, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{"srl0",      32'hDEADBEEF, 5'd0,  3'b001, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{"sra0",      32'hDEADBEEF, 5'd0,  3'b010, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{"rol0",      32'hDEADBEEF, 5'd0,  3'b011, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{"ror0",      32'hDEADBEEF, 5'd0,  3'b100, 32'hDEADBEEF, 1'b0};
        vecs[13] = '{"ill110",    32'h12345678, 5'd3,  3'b110, 32'h00000000, 1'b1};
        vecs[14] = '{"ill101",    32'hFFFFFFFF, 5'd0,  3'b101, 32'h00000000, 1'b1};
        vecs[15] = '{"rol8",      32'h12345678, 5'd8,  3'b011, 32'h34567812, 1'b0};
        vecs[16] = '{"ror4",      32'h12345678, 5'd4,  3'b100, 32'h81234567, 1'b0};
        vecs[17] = '{"srl31",     32'h80000000, 5'd31, 3'b001, 32'h00000001, 1'b0};
        vecs[18] = '{"sra31_pos", 32'h7FFFFFFF, 5'd31, 3'b010, 32'h00000000, 1'b0};
        vecs[19] = '{"rol16",     32'h0000FFFF, 5'd16, 3'b011, 32'hFFFF0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_op = '0;
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_err", out_err, 0);
        check("rst in_ready", in_ready, 1);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal op followed back-to-back by a legal one: err must not leak.
        @(negedge clk);
        in_data = 32'h12345678; in_amt = 5'd3; in_op = 3'b110; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_data = 32'h00000001; in_amt = 5'd1; in_op = 3'b000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("b2b first", seen);
        if (seen) begin
            check("b2b ill data", out_data, 0);
            check("b2b ill err", out_err, 1);
            @(negedge clk);
            check("b2b legal valid", out_valid, 1);
            check("b2b legal data", out_data, 32'h00000002);
            check("b2b legal err", out_err, 0);
        end
        repeat (6) @(negedge clk);

        // Random stream with random backpressure, checked against the model.
        sent = 0; got = 0; budget = 0; stalled = 0; acc_prev = 0;
        hold_data = '0; hold_err = 0;
        while (got < 20 && budget < 600) begin
            @(negedge clk);
            budget++;
            if (stalled) begin
                check("stall valid", out_valid, 1);
                check("stall data", out_data, hold_data);
                check("stall err", out_err, hold_err);
            end
            if (acc_prev) in_valid = 1'b0;
            if (!in_valid && sent < 20) begin
                in_data  = $urandom;
                in_amt   = LW'($urandom_range(0, W-1));
                in_op    = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 4));
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("stream extra output");
                else begin
                    e = exp_q.pop_front();
                    check("stream data", out_data, e[W-1:0]);
                    check("stream err", out_err, e[W]);
                end
                got++;
            end
            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
                exp_q.push_back(model(in_data, in_amt, in_op));
                sent++;
            end
            stalled   = out_valid && !out_ready;
            hold_data = out_data;
            hold_err  = out_err;
        end
        if (got < 20) fail_now("stream drain");
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with three ops in flight, output stage stalled.
        out_ready = 1'b0;
        in_data = 32'h0000000F; in_amt = 5'd2; in_op = 3'b000; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("pre-reset out_valid", seen);
        check("pre-reset valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", out_valid, 0);
        check("mid-rst out_data", out_data, 0);
        check("mid-rst out_err", out_err, 0);
        check("mid-rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("no ghost outputs", ghosts, 0);
        t = 0;
        run_vec('{"post-rst", 32'h000000F0, 5'd4, 3'b000, 32'h00000F00, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
